seq_multiplier_32: RTL and testbench
====================================

SEQ_MULTIPLIER_32 -- requirements
Module: seq_multiplier_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; the product is 2*WIDTH bits and only the default is required to be supported.
REQ-002 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request to begin a multiply, sampled in IDLE or DONE.
REQ-005 SHALL have port Signed  input  1  signed (mult) vs unsigned (multu) select, sampled with Start.
REQ-006 SHALL have port A  input  WIDTH  multiplicand, sampled with Start.
REQ-007 SHALL have port B  input  WIDTH  multiplier, sampled with Start.
REQ-008 SHALL have port Product  output  2*WIDTH  result, intended for the 64-bit product register data input.
REQ-009 SHALL have port Busy  output  1  high while iterating.
REQ-010 SHALL have port Done  output  1  one-cycle pulse marking Product valid, intended for the product register enable.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-012 SHALL, in IDLE with Start=1, latch A, B and Signed, clear the accumulator and the step counter, and enter BUSY on the next edge.
REQ-013 SHALL, in BUSY, perform one radix-2 shift-add step per cycle: add the multiplicand to the upper half when the current multiplier LSB is 1, then shift the 2*WIDTH-bit accumulator right by 1 with the carry-out shifted in.
REQ-014 SHALL leave BUSY for DONE after exactly WIDTH (32) BUSY cycles, so that Done asserts on the 33rd edge after Start is sampled.
REQ-015 SHALL assert Done for exactly one cycle, in DONE only, with the final Product valid in that same cycle.
REQ-016 SHALL go from DONE to BUSY when Start=1 (back-to-back operation, operands re-latched), and from DONE to IDLE otherwise.
REQ-017 SHALL ignore Start while in BUSY; operands latched for the current operation are not disturbed.
REQ-018 SHALL hold Product stable from DONE until the next accepted Start; the internal accumulator drives Product only in DONE and IDLE.
REQ-019 SHALL drive Busy=1 in BUSY only, and Busy and Done are never both high.
REQ-020 SHALL treat operands of 0 like any other value: no early termination, fixed 32-cycle latency.
REQ-021 SHALL never lose carry: the addition is WIDTH+1 bits wide.

Reset
REQ-022 SHALL, with Reset=1 at a rising edge, force state to IDLE and Product, Busy, Done, the counter and the latched operands to 0.
REQ-023 SHALL give Reset priority over Start, including Reset asserted mid-BUSY, which aborts the operation with no Done pulse.
REQ-024 SHALL accept Start on the first edge after Reset deasserts.

Configuration
REQ-025 SHALL, with SIGNED_MULT_EN defined and Signed=1, multiply two's-complement magnitudes and negate the 2*WIDTH result when the operand signs differ, at the same 32-cycle latency (sign fix-up folded into DONE entry, no extra cycle).
REQ-026 SHALL, without SIGNED_MULT_EN, ignore the Signed port and treat all operands as unsigned, with identical timing.
REQ-027 SHALL, with SIGNED_MULT_EN, produce 0x4000000000000000 for 0x80000000 * 0x80000000 signed.

Verification
REQ-028 SHALL verify this case: Reset=1 for 2 cycles, then idle -> Product=0, Busy=0, Done=0.
REQ-029 SHALL verify this case: Start with A=0xFFFFFFFF, B=0xFFFFFFFF, Signed=0 -> Busy for 32 cycles, Done pulse on the 33rd edge, Product=0xFFFFFFFE00000001.
REQ-030 SHALL verify this case: Start with A=7, B=6, then Start held high through DONE with A=3, B=5 -> Product=42 at the first Done, Product=15 at the second Done, 33 cycles apart.
REQ-031 SHALL verify this case: Start with A=0x12345678, B=0x10, then Reset=1 at BUSY cycle 10 -> no Done pulse, Product=0, state IDLE.
REQ-032 SHALL verify this case, with SIGNED_MULT_EN defined: A=0xFFFFFFFE (-2), B=3, Signed=1 -> Product=0xFFFFFFFFFFFFFFFA; the same operands with Signed=0 -> Product=0x2FFFFFFFA.
REQ-033 SHALL verify this case: Start toggled during BUSY with different A and B -> result of the original operands only, and Done still on the 33rd edge.

Source files
------------

// File: rtl/seq_multiplier_32.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_32
// Description : Radix-2 sequential shift-add multiplier. One multiply takes a
//               fixed WIDTH busy cycles. Done pulses for one cycle with the
//               final Product valid. Optional signed (two's-complement) mode
//               is compiled in with the SIGNED_MULT_EN macro. Without it, the
//               Signed port is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier_32 #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_neg;

    // Operand magnitudes and result sign, taken at the moment Start is accepted
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg_start;

    // One shift-add step and the sign-corrected final result
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_next_acc;
    logic [2*WIDTH-1:0]   w_final;

`ifdef SIGNED_MULT_EN
    localparam logic [WIDTH-1:0]   c_one_w = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_one_p = (2*WIDTH)'(1);

    // In signed mode, iterate on magnitudes; the most negative value maps to
    // its own bit pattern, which is the correct unsigned magnitude 2^(WIDTH-1)
    assign w_mag_a     = (Signed && A[WIDTH-1]) ? (~A + c_one_w) : A;
    assign w_mag_b     = (Signed && B[WIDTH-1]) ? (~B + c_one_w) : B;
    assign w_neg_start = Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
    assign w_final     = r_neg ? (~w_next_acc + c_one_p) : w_next_acc;
`else
    logic w_unused_signed;

    assign w_mag_a         = A;
    assign w_mag_b         = B;
    assign w_neg_start     = 1'b0;
    assign w_final         = w_next_acc;
    assign w_unused_signed = Signed;
`endif

    // Upper half plus multiplicand is WIDTH+1 bits so the carry is kept and
    // shifted back into the accumulator MSB.
    assign w_addend   = r_acc[0] ? {1'b0, r_mcand} : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_next_acc = {w_sum, r_acc[WIDTH-1:1]};

    // Control FSM, datapath and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        // Multiplier sits in the lower half and is consumed
                        // LSB-first as the accumulator shifts right.
                        r_mcand <= w_mag_a;
                        r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_neg   <= w_neg_start;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_next_acc;
                    if (r_count == c_last_step) begin
                        r_product <= w_final;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_count <= r_count + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Product = r_product;
    assign Busy    = r_busy;
    assign Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier_32
// Description : Directed self-checking bench for seq_multiplier_32.
//               Signed-mode vectors are active when SIGNED_MULT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_32;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] Product;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_errors = 0;

    seq_multiplier_32 #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Signed  (Signed),
        .A       (A),
        .B       (B),
        .Product (Product),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one multiply and follow it to Done; optionally wiggle Start and
    // the operands while busy to show they are ignored.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input bit toggle);
        int edges;
        int busy_n;
        int both;
        @(negedge Clk);
        Start = 1'b1; A = a; B = b; Signed = s;
        @(posedge Clk); #1;
        edges  = 0;
        busy_n = Busy ? 1 : 0;
        both   = 0;
        while (!Done && edges < 100) begin
            @(negedge Clk);
            if (toggle && edges >= 4 && edges < 10) begin
                Start = ~Start;
                A = $urandom;
                B = $urandom;
            end else begin
                Start = 1'b0;
                A = ~a;
                B = b + 32'd1;
            end
            @(posedge Clk); #1;
            edges++;
            if (Busy) busy_n++;
            if (Busy && Done) both++;
        end
        check({tag, "_latency"}, 64'(edges), 64'd32);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
        check({tag, "_busy_and_done"}, 64'(both), 64'd0);
        check({tag, "_product"}, Product, exp);
        @(posedge Clk); #1;
        check({tag, "_done_width"}, {63'd0, Done}, 64'd0);
        check({tag, "_product_hold"}, Product, exp);
    endtask

    initial begin
        int edges;
        int seen;
        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("reset_product", Product, 64'd0);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);

        run_op("max_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("zero_a", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 1'b0);
        run_op("half_by_half", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
        run_op("min_by_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        run_op("start_toggle", 32'd1000, 32'd1000, 1'b0, 64'd1000000, 1'b1);

`ifdef SIGNED_MULT_EN
        run_op("neg2_x3_signed", 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        run_op("neg_x_neg_signed", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'd42, 1'b0);
`else
        run_op("neg2_x3_signed_ignored", 32'hFFFF_FFFE, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFFA, 1'b0);
`endif
        run_op("neg2_x3_unsigned", 32'hFFFF_FFFE, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFFA, 1'b0);

        // Back-to-back: Start held high through DONE relaunches with new operands
        @(negedge Clk);
        Start = 1'b1; A = 32'd7; B = 32'd6; Signed = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        A = 32'd3; B = 32'd5;
        edges = 0;
        while (!Done && edges < 100) begin
            @(posedge Clk); #1;
            edges++;
        end
        check("b2b_first_latency", 64'(edges), 64'd32);
        check("b2b_first_product", Product, 64'd42);
        edges = 0;
        @(posedge Clk); #1;
        edges++;
        while (!Done && edges < 100) begin
            @(posedge Clk); #1;
            edges++;
        end
        Start = 1'b0;
        check("b2b_spacing", 64'(edges), 64'd33);
        check("b2b_second_product", Product, 64'd15);
        @(posedge Clk); #1;
        check("b2b_back_to_idle_busy", {63'd0, Busy}, 64'd0);

        // Reset during BUSY aborts without a Done pulse
        @(negedge Clk);
        Start = 1'b1; A = 32'h1234_5678; B = 32'h10;
        @(posedge Clk); #1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            @(posedge Clk); #1;
            if (Done) seen++;
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("abort_product", Product, 64'd0);
        check("abort_busy", {63'd0, Busy}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (Done || Busy) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // First edge after reset release accepts a new Start
        run_op("after_abort", 32'd7, 32'd6, 1'b0, 64'd42, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
